// File: rtl/cache_arbiter.sv
// ----------------------------------------------------------------------------
// cache_arbiter
//
// Shares one physical memory port between the instruction cache (read-only)
// and the data cache (read/write). One requester is granted at a time and the
// grant is held for the whole line transfer, from the request until pmem_resp.
// Address, write data and strobes are steered from the granted side; the
// memory response pulse is returned only to the granted cache.
//
// Build option:
//   CACHE_ARB_ROUND_ROBIN_EN  defined   : conflicts resolved by a priority
//                                         pointer that flips on every
//                                         completed transfer (reset: D first).
//                             undefined : the D-cache always wins a conflict.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   icache_address/read        I-cache line read request
//   icache_rdata/resp          line data and completion pulse to the I-cache
//   dcache_address/read/write  D-cache fill / writeback request
//   dcache_wdata               D-cache writeback line
//   dcache_rdata/resp          line data and completion pulse to the D-cache
//   pmem_address/read/write    physical memory command
//   pmem_wdata                 physical memory write data
//   pmem_rdata/resp            physical memory read data and completion
// ----------------------------------------------------------------------------
module cache_arbiter #(
    parameter int S_LINE = 256,
    parameter int S_ADDR = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [S_ADDR-1:0] icache_address,
    input  logic              icache_read,
    output logic [S_LINE-1:0] icache_rdata,
    output logic              icache_resp,

    input  logic [S_ADDR-1:0] dcache_address,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [S_LINE-1:0] dcache_wdata,
    output logic [S_LINE-1:0] dcache_rdata,
    output logic              dcache_resp,

    output logic [S_ADDR-1:0] pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [S_LINE-1:0] pmem_wdata,
    input  logic [S_LINE-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic ireq;
    logic dreq;

    assign ireq = icache_read;
    assign dreq = dcache_read | dcache_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    // 1 = I-cache wins the next conflict, 0 = D-cache wins.
    logic ptr_q;
    logic ptr_d;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (ireq && dreq) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                    state_d = ptr_q ? GRANT_I : GRANT_D;
`else
                    state_d = GRANT_D;
`endif
                end else if (ireq) begin
                    state_d = GRANT_I;
                end else if (dreq) begin
                    state_d = GRANT_D;
                end
            end
            GRANT_I, GRANT_D: begin
                // The grant is released only by the memory; a requester
                // dropping its request does not abandon the transfer.
                if (pmem_resp) begin
                    state_d = IDLE;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                    ptr_d   = ~ptr_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Output steering: selected by the registered state, so a new request
    // only reaches memory one cycle after it is first seen in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        icache_resp  = 1'b0;
        dcache_resp  = 1'b0;
        case (state_q)
            GRANT_I: begin
                pmem_address = icache_address;
                pmem_read    = 1'b1;
                icache_resp  = pmem_resp;
            end
            GRANT_D: begin
                pmem_address = dcache_address;
                pmem_read    = dcache_read;
                pmem_write   = dcache_write;
                pmem_wdata   = dcache_wdata;
                dcache_resp  = pmem_resp;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; only the resp pulses qualify it.
    assign icache_rdata = pmem_rdata;
    assign dcache_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cache_arbiter
//
// Self-checking bench for cache_arbiter: a cycle table of directed vectors,
// a hand-written conflict sequence, and randomized traffic compared against
// a transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_cache_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] icache_address;
    logic          icache_read;
    logic [LW-1:0] icache_rdata;
    logic          icache_resp;
    logic [AW-1:0] dcache_address;
    logic          dcache_read;
    logic          dcache_write;
    logic [LW-1:0] dcache_wdata;
    logic [LW-1:0] dcache_rdata;
    logic          dcache_resp;
    logic [AW-1:0] pmem_address;
    logic          pmem_read;
    logic          pmem_write;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    cache_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .icache_address (icache_address),
        .icache_read    (icache_read),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_address (dcache_address),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .pmem_address   (pmem_address),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 20)
                $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd256();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Directed cycle table: inputs for one cycle and the outputs expected
    // in that same cycle.
    // ------------------------------------------------------------------
    typedef struct {
        logic          rst, ir, dr, dw, resp;
        logic [AW-1:0] ia, da;
        logic          e_rd, e_wr, e_ir, e_dr, e_wd;
        logic [AW-1:0] e_addr;
    } vec_t;

    function automatic vec_t mk(input logic r, ir, dr, dw, rs,
                                input logic [AW-1:0] ia, da,
                                input logic e_rd, e_wr, e_ir, e_dr, e_wd,
                                input logic [AW-1:0] e_addr);
        vec_t v;
        v.rst = r;  v.ir = ir; v.dr = dr; v.dw = dw; v.resp = rs;
        v.ia = ia;  v.da = da;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_ir = e_ir; v.e_dr = e_dr;
        v.e_wd = e_wd; v.e_addr = e_addr;
        return v;
    endfunction

    localparam logic [LW-1:0] RD_LINE = {8{32'hA5A5_A5A5}};
    localparam logic [LW-1:0] WD_LINE = {8{32'h1234_5678}};

    vec_t vecs[29];

    task automatic apply_inputs(input logic r, ir, dr, dw, rs, input logic [AW-1:0] ia, da);
        rst = r; icache_read = ir; dcache_read = dr; dcache_write = dw;
        pmem_resp = rs; icache_address = ia; dcache_address = da;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        apply_inputs(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Reference model: who owns the memory port, and who wins a tie.
    // ------------------------------------------------------------------
    int owner;      // 0 = nobody, 1 = I-cache, 2 = D-cache
    bit prio_i;     // I-cache wins next tie (round-robin build only)

    task automatic model_step();
        if (rst) begin
            owner  = 0;
            prio_i = 1'b0;
        end else if (owner == 0) begin
            if (icache_read && (dcache_read || dcache_write))
                owner = (RR && prio_i) ? 1 : 2;
            else if (icache_read)
                owner = 1;
            else if (dcache_read || dcache_write)
                owner = 2;
        end else if (pmem_resp) begin
            owner = 0;
            if (RR) prio_i = !prio_i;
        end
    endtask

    initial begin
        // Conflict expectations: 1 = I, 2 = D.
        int exp_grant[4];
        int got;
        bit found;

        apply_inputs(1, 0, 0, 0, 0, 0, 0);
        dcache_wdata = WD_LINE;
        pmem_rdata   = RD_LINE;

        //                r  ir dr dw rs  ia      da        rd wr ir dr wd addr
        vecs[0]  = mk(0, 0, 0, 0, 0, 32'h0,  32'h0,    0, 0, 0, 0, 0, 32'h0);    // reset state
        // solo I-read, memory answers on the third granted cycle
        vecs[1]  = mk(0, 1, 0, 0, 0, 32'h60, 32'h0,    0, 0, 0, 0, 0, 32'h0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 32'h60, 32'h0,    1, 0, 0, 0, 0, 32'h60);
        vecs[3]  = mk(0, 1, 0, 0, 0, 32'h60, 32'h0,    1, 0, 0, 0, 0, 32'h60);
        vecs[4]  = mk(0, 1, 0, 0, 1, 32'h60, 32'h0,    1, 0, 1, 0, 0, 32'h60);
        vecs[5]  = mk(0, 0, 0, 0, 0, 32'h60, 32'h0,    0, 0, 0, 0, 0, 32'h0);
        // solo D-writeback
        vecs[6]  = mk(0, 0, 0, 1, 0, 32'h0,  32'h1000, 0, 0, 0, 0, 0, 32'h0);
        vecs[7]  = mk(0, 0, 0, 1, 0, 32'h0,  32'h1000, 0, 1, 0, 0, 1, 32'h1000);
        vecs[8]  = mk(0, 0, 0, 1, 1, 32'h0,  32'h1000, 0, 1, 0, 1, 1, 32'h1000);
        vecs[9]  = mk(0, 0, 0, 0, 0, 32'h0,  32'h1000, 0, 0, 0, 0, 0, 32'h0);
        // I request dropped one cycle after grant
        vecs[10] = mk(0, 1, 0, 0, 0, 32'h80, 32'h0,    0, 0, 0, 0, 0, 32'h0);
        vecs[11] = mk(0, 1, 0, 0, 0, 32'h80, 32'h0,    1, 0, 0, 0, 0, 32'h80);
        vecs[12] = mk(0, 0, 0, 0, 0, 32'h80, 32'h0,    1, 0, 0, 0, 0, 32'h80);
        vecs[13] = mk(0, 0, 0, 0, 0, 32'h80, 32'h0,    1, 0, 0, 0, 0, 32'h80);
        vecs[14] = mk(0, 0, 0, 0, 1, 32'h80, 32'h0,    1, 0, 1, 0, 0, 32'h80);
        vecs[15] = mk(0, 0, 0, 0, 0, 32'h0,  32'h0,    0, 0, 0, 0, 0, 32'h0);
        // stray pmem_resp in IDLE is ignored
        vecs[16] = mk(0, 0, 0, 0, 1, 32'h0,  32'h0,    0, 0, 0, 0, 0, 32'h0);
        // reset during a D-read, late pmem_resp afterwards
        vecs[17] = mk(0, 0, 1, 0, 0, 32'h0,  32'h2000, 0, 0, 0, 0, 0, 32'h0);
        vecs[18] = mk(0, 0, 1, 0, 0, 32'h0,  32'h2000, 1, 0, 0, 0, 1, 32'h2000);
        vecs[19] = mk(1, 0, 1, 0, 0, 32'h0,  32'h2000, 1, 0, 0, 0, 1, 32'h2000);
        vecs[20] = mk(0, 0, 0, 0, 1, 32'h0,  32'h2000, 0, 0, 0, 0, 0, 32'h0);
        vecs[21] = mk(0, 0, 0, 0, 0, 32'h0,  32'h0,    0, 0, 0, 0, 0, 32'h0);
        // back-to-back I reads: one IDLE cycle, next strobe at M+2
        vecs[22] = mk(0, 1, 0, 0, 0, 32'h40, 32'h0,    0, 0, 0, 0, 0, 32'h0);
        vecs[23] = mk(0, 1, 0, 0, 0, 32'h40, 32'h0,    1, 0, 0, 0, 0, 32'h40);
        vecs[24] = mk(0, 1, 0, 0, 1, 32'h40, 32'h0,    1, 0, 1, 0, 0, 32'h40);
        vecs[25] = mk(0, 1, 0, 0, 0, 32'h40, 32'h0,    0, 0, 0, 0, 0, 32'h0);
        vecs[26] = mk(0, 1, 0, 0, 0, 32'h40, 32'h0,    1, 0, 0, 0, 0, 32'h40);
        vecs[27] = mk(0, 1, 0, 0, 1, 32'h40, 32'h0,    1, 0, 1, 0, 0, 32'h40);
        vecs[28] = mk(0, 0, 0, 0, 0, 32'h0,  32'h0,    0, 0, 0, 0, 0, 32'h0);

        // ---------------- directed table ----------------
        do_reset();
        for (int i = 0; i < 29; i++) begin
            string tag;
            if (i > 0) begin
                @(posedge clk); #1;
            end
            apply_inputs(vecs[i].rst, vecs[i].ir, vecs[i].dr, vecs[i].dw, vecs[i].resp,
                         vecs[i].ia, vecs[i].da);
            @(negedge clk);
            tag = $sformatf("row%0d", i);
            chk({tag, ".pmem_read"},    LW'(pmem_read),    LW'(vecs[i].e_rd));
            chk({tag, ".pmem_write"},   LW'(pmem_write),   LW'(vecs[i].e_wr));
            chk({tag, ".icache_resp"},  LW'(icache_resp),  LW'(vecs[i].e_ir));
            chk({tag, ".dcache_resp"},  LW'(dcache_resp),  LW'(vecs[i].e_dr));
            chk({tag, ".pmem_address"}, LW'(pmem_address), LW'(vecs[i].e_addr));
            chk({tag, ".pmem_wdata"},   pmem_wdata,        vecs[i].e_wd ? WD_LINE : '0);
            if (vecs[i].e_ir) chk({tag, ".icache_rdata"}, icache_rdata, RD_LINE);
            if (vecs[i].e_dr) chk({tag, ".dcache_rdata"}, dcache_rdata, RD_LINE);
            $display("row %0d: rd=%0b wr=%0b iresp=%0b dresp=%0b addr=%h",
                     i, pmem_read, pmem_write, icache_resp, dcache_resp, pmem_address);
        end

        // ---------------- sustained conflict ----------------
        if (RR) begin
            exp_grant[0] = 2; exp_grant[1] = 1; exp_grant[2] = 2; exp_grant[3] = 1;
        end else begin
            exp_grant[0] = 2; exp_grant[1] = 2; exp_grant[2] = 2; exp_grant[3] = 2;
        end
        do_reset();
        apply_inputs(0, 1, 1, 0, 0, 32'h100, 32'h200);
        for (int t = 0; t < 4; t++) begin
            found = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (pmem_read) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) begin
                chk($sformatf("conflict%0d.grant_timeout", t), LW'(0), LW'(1));
                break;
            end
            got = (pmem_address == 32'h200) ? 2 : 1;
            chk($sformatf("conflict%0d.winner", t), LW'(got), LW'(exp_grant[t]));
            @(posedge clk); #1;
            pmem_resp = 1'b1;
            @(negedge clk);
            chk($sformatf("conflict%0d.icache_resp", t), LW'(icache_resp), LW'(exp_grant[t] == 1));
            chk($sformatf("conflict%0d.dcache_resp", t), LW'(dcache_resp), LW'(exp_grant[t] == 2));
            $display("transfer %0d granted to %s", t, (got == 2) ? "D" : "I");
            @(posedge clk); #1;
            pmem_resp = 1'b0;
        end

        // ---------------- randomized traffic vs model ----------------
        apply_inputs(1, 0, 0, 0, 0, 0, 0);
        owner  = 0;
        prio_i = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            logic [AW-1:0] e_addr;
            logic          e_rd, e_wr, e_ir, e_dr;
            logic [LW-1:0] e_wd;
            int            op;
            @(posedge clk);
            model_step();
            #1;
            op             = $urandom_range(0, 3);
            rst            = ($urandom_range(0, 99) == 0);
            icache_read    = $urandom_range(0, 1);
            dcache_read    = (op == 1);
            dcache_write   = (op == 2);
            pmem_resp      = ($urandom_range(0, 2) == 0);
            icache_address = $urandom;
            dcache_address = $urandom;
            dcache_wdata   = rnd256();
            pmem_rdata     = rnd256();
            @(negedge clk);
            e_addr = '0; e_rd = 0; e_wr = 0; e_ir = 0; e_dr = 0; e_wd = '0;
            if (owner == 1) begin
                e_addr = icache_address; e_rd = 1'b1; e_ir = pmem_resp;
            end else if (owner == 2) begin
                e_addr = dcache_address; e_rd = dcache_read; e_wr = dcache_write;
                e_wd = dcache_wdata; e_dr = pmem_resp;
            end
            chk($sformatf("rand%0d.strobes", n),
                LW'({pmem_read, pmem_write, icache_resp, dcache_resp}),
                LW'({e_rd, e_wr, e_ir, e_dr}));
            chk($sformatf("rand%0d.pmem_address", n), LW'(pmem_address), LW'(e_addr));
            chk($sformatf("rand%0d.pmem_wdata", n), pmem_wdata, e_wd);
            chk($sformatf("rand%0d.rdata", n),
                LW'({icache_rdata == pmem_rdata, dcache_rdata == pmem_rdata}), LW'(2'b11));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
